// File: rtl/pulse_stretcher_if.sv
// Trigger/level bundle between control logic (master) and the pulse stretcher (slave).
interface pulse_stretcher_if #(
  parameter int PEND_W = 3
);
  logic              trig;
  logic              outp;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (
    output trig,
    input  outp,
    input  busy,
    input  pending,
    input  overflow
  );

  modport slave (
    input  trig,
    output outp,
    output busy,
    output pending,
    output overflow
  );
endinterface

// File: rtl/pulse_stretcher.sv
// Turns 1-cycle triggers into HIGH_CYCLES-high / GAP_CYCLES-low bursts; outp rises 1 cycle after trig.
// No backpressure: triggers during a burst queue in a saturating counter, excess ones are dropped and flagged.
module pulse_stretcher #(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  pulse_stretcher_if.slave bus
);

  localparam int CNT_SPAN  = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int CNT_RANGE = (CNT_SPAN > 2) ? CNT_SPAN : 2;
  localparam int CNT_W     = $clog2(CNT_RANGE);

  localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam bit                HAS_GAP   = (GAP_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [PEND_W-1:0] pend_q;
  logic [PEND_W-1:0] pend_d;
  logic              ovf_d;
  logic              ovf_q;
  logic              outp_q;
  logic              busy_q;
  logic              cnt_zero;
  logic              burst_end;
  logic              queued;

  assign cnt_zero = (cnt_q == '0);
  assign queued   = (pend_q != '0) || bus.trig;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // burst_end marks the last cycle of a burst, where a queued or fresh trigger restarts HIGH back-to-back.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    burst_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.trig) begin
          state_d = HIGH;
          cnt_d   = HIGH_LOAD;
        end
      end
      HIGH: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else if (HAS_GAP) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          burst_end = 1'b1;
        end
      end
      GAP: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          burst_end = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (burst_end) begin
      if (queued) begin
        state_d = HIGH;
        cnt_d   = HIGH_LOAD;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  // At burst end a fresh trigger replaces the consumed queue slot, so the count cannot overflow there.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = 1'b0;
    if (burst_end) begin
      if (!bus.trig && (pend_q != '0)) begin
        pend_d = pend_q - 1'b1;
      end
    end else if ((state_q != IDLE) && bus.trig) begin
      if (pend_q != PEND_MAX) begin
        pend_d = pend_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
      outp_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      outp_q <= (state_d == HIGH);
      busy_q <= (state_d != IDLE);
    end
  end

  assign bus.outp     = outp_q;
  assign bus.busy     = busy_q;
  assign bus.pending  = pend_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: three parameterisations against a burst-position model plus literal cycle checks.
module tb_pulse_stretcher;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic t_def = 1'b0;
  logic t_h16 = 1'b0;
  logic t_g0  = 1'b0;
  int   cyc;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pulse_stretcher_if #(.PEND_W(3)) if_def ();
  pulse_stretcher_if #(.PEND_W(3)) if_h16 ();
  pulse_stretcher_if #(.PEND_W(3)) if_g0 ();

  assign if_def.trig = t_def;
  assign if_h16.trig = t_h16;
  assign if_g0.trig  = t_g0;

  pulse_stretcher #(.HIGH_CYCLES(4), .GAP_CYCLES(2), .PEND_W(3)) dut_def (
    .clk(clk), .rst(rst), .bus(if_def));
  pulse_stretcher #(.HIGH_CYCLES(16), .GAP_CYCLES(2), .PEND_W(3)) dut_h16 (
    .clk(clk), .rst(rst), .bus(if_h16));
  pulse_stretcher #(.HIGH_CYCLES(4), .GAP_CYCLES(0), .PEND_W(3)) dut_g0 (
    .clk(clk), .rst(rst), .bus(if_g0));

  // Model: a burst is a window of h+g cycles, tracked only by position within it.
  typedef struct {
    bit active;
    int pos;
    int pend;
    bit outp;
    bit busy;
    bit ovf;
  } mdl_t;

  mdl_t m_def, m_h16, m_g0;

  function automatic mdl_t step(input mdl_t m, input bit trig, input int h, input int g, input int pmax);
    mdl_t n;
    n = m;
    n.ovf = 1'b0;
    if (!m.active) begin
      if (trig) begin
        n.active = 1'b1;
        n.pos    = 0;
      end
    end else if (m.pos == h + g - 1) begin
      if (m.pend + int'(trig) > 0) begin
        n.pos  = 0;
        n.pend = m.pend + int'(trig) - 1;
      end else begin
        n.active = 1'b0;
      end
    end else begin
      n.pos = m.pos + 1;
      if (trig) begin
        if (m.pend < pmax) n.pend = m.pend + 1;
        else n.ovf = 1'b1;
      end
    end
    n.outp = n.active && (n.pos < h);
    n.busy = n.active;
    return n;
  endfunction

  function automatic mdl_t mdl_zero();
    mdl_t z;
    z.active = 1'b0; z.pos = 0; z.pend = 0; z.outp = 1'b0; z.busy = 1'b0; z.ovf = 1'b0;
    return z;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_def = mdl_zero();
      m_h16 = mdl_zero();
      m_g0  = mdl_zero();
    end else begin
      m_def = step(m_def, t_def, 4, 2, 7);
      m_h16 = step(m_h16, t_h16, 16, 2, 7);
      m_g0  = step(m_g0, t_g0, 4, 0, 7);
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0b expected=%0b", nm, cyc, act, exp);
    end
  endtask

  task automatic chkp(input string nm, input logic [2:0] act, input logic [2:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic cmp_inst(input string nm, input logic o, input logic b, input logic [2:0] p,
                          input logic ov, input mdl_t m);
    chk1({nm, ".outp"}, o, m.outp);
    chk1({nm, ".busy"}, b, m.busy);
    chkp({nm, ".pending"}, p, 3'(m.pend));
    chk1({nm, ".overflow"}, ov, m.ovf);
  endtask

  always @(negedge clk) begin
    cmp_inst("def", if_def.outp, if_def.busy, if_def.pending, if_def.overflow, m_def);
    cmp_inst("h16", if_h16.outp, if_h16.busy, if_h16.pending, if_h16.overflow, m_h16);
    cmp_inst("g0", if_g0.outp, if_g0.busy, if_g0.pending, if_g0.overflow, m_g0);
  end

  task automatic goto(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 200) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic all_zero(input string nm);
    chk1({nm, ".def.outp"}, if_def.outp, 1'b0);
    chk1({nm, ".def.busy"}, if_def.busy, 1'b0);
    chkp({nm, ".def.pending"}, if_def.pending, 3'd0);
    chk1({nm, ".h16.busy"}, if_h16.busy, 1'b0);
    chkp({nm, ".h16.pending"}, if_h16.pending, 3'd0);
    chk1({nm, ".g0.busy"}, if_g0.busy, 1'b0);
  endtask

  task automatic do_reset();
    t_def = 1'b0;
    t_h16 = 1'b0;
    t_g0  = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    all_zero("reset");
    rst = 1'b0;
  endtask

  initial begin
    int p;
    // Run A: single burst (default), held trigger with overflow (HIGH=16), merged bursts (GAP=0).
    do_reset();
    for (int c = 1; c <= 40; c++) begin
      goto(c);
      t_def = (c == 10);
      t_h16 = (c >= 10 && c <= 19);
      t_g0  = (c == 10 || c == 11);
      if (c >= 9 && c <= 18) begin
        chk1("t1.outp", if_def.outp, (c >= 11 && c <= 14));
        chk1("t1.busy", if_def.busy, (c >= 11 && c <= 16));
        chkp("t1.pending", if_def.pending, 3'd0);
      end
      if (c >= 11 && c <= 22) begin
        chkp("t3.pending", if_h16.pending, (c <= 11) ? 3'd0 : ((c >= 18) ? 3'd7 : 3'(c - 11)));
        chk1("t3.overflow", if_h16.overflow, (c == 19 || c == 20));
      end
      if (c >= 9 && c <= 20) begin
        chk1("t6.outp", if_g0.outp, (c >= 11 && c <= 18));
        chk1("t6.busy", if_g0.busy, (c >= 11 && c <= 18));
      end
      if (c == 12) chk1("model.t1.outp12", m_def.outp, 1'b1);
      if (c == 15) chk1("model.t1.outp15", m_def.outp, 1'b0);
      if (c == 17) chk1("model.t1.busy17", m_def.busy, 1'b0);
      if (c == 20) chkp("model.t3.pend20", 3'(m_h16.pend), 3'd7);
      if (c == 20) chk1("model.t3.ovf20", m_h16.ovf, 1'b1);
      if (c == 18) chk1("model.t6.outp18", m_g0.outp, 1'b1);
    end

    // Run B: second trigger queues during the first burst.
    do_reset();
    for (int c = 1; c <= 26; c++) begin
      goto(c);
      t_def = (c == 10 || c == 12);
      if (c >= 11) begin
        chkp("t2.pending", if_def.pending, (c >= 13 && c <= 16) ? 3'd1 : 3'd0);
        chk1("t2.outp", if_def.outp, (c <= 14) || (c >= 17 && c <= 20));
        chk1("t2.busy", if_def.busy, (c <= 22));
      end
    end

    // Run C: trigger in the last gap cycle restarts without an idle cycle.
    do_reset();
    for (int c = 1; c <= 26; c++) begin
      goto(c);
      t_def = (c == 10 || c == 16);
      if (c >= 11) begin
        chk1("t4.outp", if_def.outp, (c <= 14) || (c >= 17 && c <= 20));
        chk1("t4.busy", if_def.busy, (c <= 22));
        chkp("t4.pending", if_def.pending, 3'd0);
      end
    end

    // Run D: asynchronous reset mid-burst with a non-empty queue.
    do_reset();
    for (int c = 1; c <= 13; c++) begin
      goto(c);
      t_def = (c >= 9 && c <= 12);
    end
    chkp("t5.pending_pre", if_def.pending, 3'd3);
    chk1("t5.outp_pre", if_def.outp, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("t5.outp_rst", if_def.outp, 1'b0);
    chk1("t5.busy_rst", if_def.busy, 1'b0);
    chkp("t5.pending_rst", if_def.pending, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk1("t5.outp_after", if_def.outp, 1'b0);
    end

    // Run E: random triggers at rising densities with occasional async resets.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      p = (k < 1000) ? 15 : ((k < 2000) ? 45 : 85);
      t_def = ($urandom_range(99) < 32'(p));
      t_h16 = ($urandom_range(99) < 32'(p));
      t_g0  = ($urandom_range(99) < 32'(p));
      if (k % 900 == 450) begin
        #2 rst = 1'b1;
        #1 all_zero("rand_rst");
        @(negedge clk);
        rst = 1'b0;
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
